// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding ID.
// Owns the PC, drives the instruction SRAM over a req/addr_ok/data_ok
// handshake with at most one request in flight, and holds one fetched
// instruction for ID as {out_valid, out_pc} plus the instruction word.
// Redirects: rst > flush (new_pc) > br_e (br_addr). stall[1] holds IF.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush, new_pc        exception/eret redirect and its target
//   br_e, br_addr        taken branch and its target
//   stall[5:0]           pipeline stall vector, bit 1 holds IF
//   stallreq             1 while ID would receive no instruction
//   inst_sram_*          SRAM request/response handshake
//   ic_to_id_bus[32:0]   {out_valid, out_pc}
//   ic_inst[31:0]        instruction paired with out_pc (0 when invalid)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic [5:0]  stall,
  output logic        stallreq,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [32:0] ic_to_id_bus,
  output logic [31:0] ic_inst
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            fsm;
  logic [XLEN-1:0]   pc;
  logic              cancel;
  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_inst;

  logic              hold;
  logic              accept;
  logic              can_take;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              req_acc;
  logic              resp;
  logic              take;
  logic              in_flight_next;
  logic              stall_unused;

  // Only bit 1 of the stall vector concerns this stage.
  assign stall_unused = ^{stall[5:2], stall[0]};

  // Handshake and redirect decode.
  always_comb begin
    hold           = stall[1];
    accept         = out_valid & ~hold;
    can_take       = ~out_valid | accept;
    redirect       = flush | br_e;
    target         = flush ? new_pc : br_addr;
    inst_sram_req  = ~rst & (fsm == S_REQ) & can_take;
    req_acc        = inst_sram_req & inst_sram_addr_ok;
    resp           = (fsm == S_WAIT) & inst_sram_data_ok;
    // A redirect wins over same-cycle data; cancelled responses are dropped.
    take           = resp & ~cancel & ~redirect;
    // A request is still outstanding after this edge.
    in_flight_next = req_acc | ((fsm == S_WAIT) & ~inst_sram_data_ok);
    stallreq       = ~rst & ~flush & ~out_valid & ~take;
  end

  assign inst_sram_addr = pc;
  assign ic_to_id_bus   = {out_valid, out_pc};
  assign ic_inst        = out_inst;

  // Fetch FSM, PC, cancel flag and the ID-facing holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_REQ;
      pc        <= RESET_PC;
      cancel    <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else begin
      case (fsm)
        S_REQ:   if (req_acc)           fsm <= S_WAIT;
        S_WAIT:  if (inst_sram_data_ok) fsm <= S_REQ;
        default:                        fsm <= S_REQ;
      endcase

      // Completing response always clears cancel; a redirect with a request
      // still outstanding marks its eventual data for discard.
      if (resp)
        cancel <= 1'b0;
      else if (redirect && in_flight_next)
        cancel <= 1'b1;

      if (redirect) begin
        pc        <= target;
        out_valid <= 1'b0;
        out_pc    <= '0;
        out_inst  <= '0;
      end else if (take) begin
        pc        <= pc + XLEN'(4);
        out_valid <= 1'b1;
        out_pc    <= pc;
        out_inst  <= inst_sram_rdata;
      end else if (accept) begin
        out_valid <= 1'b0;
        out_pc    <= '0;
        out_inst  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed, table-driven bench for if_fetch. Each row drives
// one cycle of inputs and lists the outputs expected in that cycle; a
// hand-written sequence covers a reset pulse with a late SRAM response.
module tb_if_fetch;

  localparam logic [31:0] R    = 32'hBFC0_0000;
  localparam logic [31:0] B100 = 32'hBFC0_0100;
  localparam logic [31:0] EXC  = 32'hBFC0_0380;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] I1   = 32'h2401_0001;
  localparam logic [31:0] I2   = 32'h2402_0002;
  localparam logic [31:0] I3   = 32'h3C1D_A000;
  localparam logic [31:0] I4   = 32'h8C02_0010;
  localparam logic [31:0] I5   = 32'h1111_1111;
  localparam logic [31:0] I6   = 32'h2222_2222;
  localparam logic [31:0] I7   = 32'h3333_3333;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic [5:0]  stall;
  logic        stallreq;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [32:0] ic_to_id_bus;
  logic [31:0] ic_inst;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .new_pc            (new_pc),
    .br_e              (br_e),
    .br_addr           (br_addr),
    .stall             (stall),
    .stallreq          (stallreq),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ic_to_id_bus      (ic_to_id_bus),
    .ic_inst           (ic_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          fl;
    logic [31:0] npc;
    bit          br;
    logic [31:0] bra;
    bit          st;
    bit          ao;
    bit          dok;
    logic [31:0] rd;
    bit          ereq;
    logic [31:0] eaddr;
    bit          esreq;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit fl, logic [31:0] npc, bit br,
                              logic [31:0] bra, bit st, bit ao, bit dok,
                              logic [31:0] rd, bit ereq, logic [31:0] eaddr,
                              bit esreq, bit ev, logic [31:0] epc,
                              logic [31:0] einst);
    vec_t v;
    v.rst = r;   v.fl = fl;     v.npc = npc;     v.br = br;   v.bra = bra;
    v.st = st;   v.ao = ao;     v.dok = dok;     v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.esreq = esreq;
    v.ev = ev;   v.epc = epc;   v.einst = einst;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [32:0] act,
                     input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Non-stall bits are set when IF is not held, so only bit 1 may matter.
  task automatic drive(input vec_t v);
    rst               = v.rst;
    flush             = v.fl;
    new_pc            = v.npc;
    br_e              = v.br;
    br_addr           = v.bra;
    stall             = v.st ? 6'b000010 : 6'b111101;
    inst_sram_addr_ok = v.ao;
    inst_sram_data_ok = v.dok;
    inst_sram_rdata   = v.rd;
  endtask

  task automatic check_row(input vec_t v, input int idx);
    chk("req",      idx, 33'(inst_sram_req),  33'(v.ereq));
    chk("addr",     idx, 33'(inst_sram_addr), 33'(v.eaddr));
    chk("stallreq", idx, 33'(stallreq),       33'(v.esreq));
    chk("bus",      idx, ic_to_id_bus,        {v.ev, v.epc});
    chk("inst",     idx, 33'(ic_inst),        33'(v.einst));
  endtask

  initial begin
    bit done;

    // reset state
    vecs.push_back(mk(1,0,0,0,0,          0,0,0,0,   0,R,0,0,0,0));
    // zero-wait fetch of two instructions
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,R,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I1,  0,R,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,R+4,0,1,R,I1));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I2,  0,R+4,0,0,0,0));
    // stall hold for 3 cycles with a valid instruction, then release
    vecs.push_back(mk(0,0,0,0,0,          1,1,0,0,   0,R+8,0,1,R+4,I2));
    vecs.push_back(mk(0,0,0,0,0,          1,1,0,0,   0,R+8,0,1,R+4,I2));
    vecs.push_back(mk(0,0,0,0,0,          1,1,0,0,   0,R+8,0,1,R+4,I2));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,R+8,0,1,R+4,I2));
    // branch while waiting; the late data is cancelled
    vecs.push_back(mk(0,0,0,1,B100,       0,0,0,0,   0,R+8,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,BAD, 0,B100,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,B100,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I3,  0,B100,0,0,0,0));
    // flush and branch together, request accepted the same cycle
    vecs.push_back(mk(0,1,EXC,1,32'h8000_1000, 0,1,0,0, 1,B100+4,0,1,B100,I3));
    vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,   0,EXC,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,BAD, 0,EXC,1,0,0,0));
    // data_ok delayed 5 cycles
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,EXC,1,0,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,        0,0,0,0,   0,EXC,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I4,  0,EXC,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          1,0,0,0,   0,EXC+4,0,1,EXC,I4));
    // flush during stall with nothing outstanding, then PC wrap
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0, 1,0,0,0, 0,EXC+4,0,1,EXC,I4));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'hFFFF_FFFC,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I5,  0,32'hFFFF_FFFC,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,0,0,   1,0,0,1,32'hFFFF_FFFC,I5));
    // branch in S_REQ without addr_ok: next request uses the target
    vecs.push_back(mk(0,0,0,1,32'h40,     0,0,0,0,   1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'h40,1,0,0,0));
    // branch with same-cycle data_ok: data dropped, no lingering cancel
    vecs.push_back(mk(0,0,0,1,32'h80,     0,0,1,BAD, 0,32'h40,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'h80,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,I6,  0,32'h80,0,0,0,0));
    // data captured under stall while out_valid=0
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'h84,0,1,32'h80,I6));
    vecs.push_back(mk(0,0,0,0,0,          1,0,1,I7,  0,32'h84,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          1,1,0,0,   0,32'h88,0,1,32'h84,I7));
    // redirect while already cancelling
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'h88,0,1,32'h84,I7));
    vecs.push_back(mk(0,0,0,1,32'h100,    0,0,0,0,   0,32'h88,1,0,0,0));
    vecs.push_back(mk(0,1,32'h200,0,0,    0,0,0,0,   0,32'h100,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,0,1,BAD, 0,32'h200,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,          0,1,0,0,   1,32'h200,1,0,0,0));

    drive(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_row(vecs[i], i);
    end

    // Reset pulse while waiting, late data_ok the cycle after.
    @(negedge clk);
    drive(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #1;
    chk("rst_req",      100, 33'(inst_sram_req), 33'(0));
    chk("rst_stallreq", 100, 33'(stallreq),      33'(0));
    @(negedge clk);
    drive(mk(0,0,0,0,0, 0,0,1,BAD, 0,0,0,0,0,0));
    #1;
    chk("late_req",  101, 33'(inst_sram_req),  33'(1));
    chk("late_addr", 101, 33'(inst_sram_addr), 33'(R));
    chk("late_bus",  101, ic_to_id_bus,        33'(0));
    @(negedge clk);
    drive(mk(0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,0));
    #1;
    chk("late_inst", 102, 33'(ic_inst),        33'(0));
    chk("late_bus2", 102, ic_to_id_bus,        33'(0));
    chk("late_req2", 102, 33'(inst_sram_req),  33'(1));

    // Bounded wait for the refetched instruction.
    done = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      @(negedge clk);
      drive(mk(0,0,0,0,0, 1,0,1,I1, 0,0,0,0,0,0));
      #1;
      if (ic_to_id_bus[32]) done = 1'b1;
    end
    chk("refetch_timeout", 103, 33'(done),          33'(1));
    chk("refetch_bus",     103, ic_to_id_bus,       {1'b1, R});
    chk("refetch_inst",    103, 33'(ic_inst),       33'(I1));
    chk("refetch_addr",    103, 33'(inst_sram_addr), 33'(R + 32'd4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
